// File: rtl/full_adder_tester.sv
// full_adder_tester: on-chip stimulus/response checker for a single-bit full adder
// Ports: clock, reset (async, active low); io_start/io_abort control a run;
// io_a/io_b/io_cin drive the adder and io_sum/io_cout are its response;
// io_busy/io_done/io_pass give status; io_err_count/io_first_fail_* record mismatches.
module full_adder_tester #(
  parameter int NUM_VECTORS = 64,
  parameter int SAMPLE_DELAY = 0,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic clock,
  input  logic reset,
  input  logic io_start,
  input  logic io_abort,
  input  logic io_sum,
  input  logic io_cout,
  output logic io_a,
  output logic io_b,
  output logic io_cin,
  output logic io_busy,
  output logic io_done,
  output logic io_pass,
  output logic [15:0] io_err_count,
  output logic [15:0] io_first_fail_idx,
  output logic [2:0] io_first_fail_vec
);
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);
  localparam logic [3:0] DELAY = 4'(SAMPLE_DELAY);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [15:0] k;
  logic [3:0] timer;
  logic [7:0] lfsr;
  logic aborted, launch, compare, mismatch;
  logic [2:0] vec;
  assign launch = io_start && (state != RUN);
  // an abort on the sampling edge suppresses that compare
  assign compare = (state == RUN) && !io_abort && (timer == DELAY);
  // vectors 0..7 sweep the whole truth table, later ones come from the LFSR
  assign vec = (k < 16'd8) ? k[2:0] : lfsr[2:0];
  assign mismatch = (io_sum != ^vec) || (io_cout != ((vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0])));
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = launch ? RUN : ((state == RUN) && (io_abort || (compare && (k == LAST)))) ? DONE : state;
  always_comb begin
    io_busy = state == RUN;
    io_done = state == DONE;
    io_pass = io_done && (io_err_count == 16'd0) && !aborted;
    {io_a, io_b, io_cin} = io_busy ? vec : 3'b000;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset || launch) begin
      k <= '0;
      timer <= '0;
      lfsr <= SEED;
      aborted <= 1'b0;
      io_err_count <= '0;
      io_first_fail_idx <= '0;
      io_first_fail_vec <= '0;
    end else if (state == RUN) begin
      if (io_abort) aborted <= 1'b1;
      else if (compare) begin
        timer <= '0;
        k <= k + 16'd1;
        // step the LFSR so it is fresh when vector k+1 (>= 8) goes out
        if (k >= 16'd7) lfsr <= {lfsr[6:0], ^(lfsr & 8'hB8)};
        if (mismatch) begin
          if (io_err_count == 16'd0) begin
            io_first_fail_idx <= k;
            io_first_fail_vec <= vec;
          end
          if (io_err_count != 16'hFFFF) io_err_count <= io_err_count + 16'd1;
        end
      end else timer <= timer + 4'd1;
    end
endmodule

// File: tb/tb_full_adder_tester.sv
// tb_full_adder_tester: checks two tester instances (delay 0 and delay 2) against a bench-side adder with fault modes
module tb_full_adder_tester;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  int mode = 0, n_checks = 0, n_fail = 0, c = 0;
  logic a [2], b [2], ci [2], sum [2], cout [2], busy [2], done [2], pass [2];
  logic [15:0] err [2];
  logic [15:0] ffi [2];
  logic [2:0] ffv [2];
  always #5 clk = ~clk;
  full_adder_tester #(.NUM_VECTORS(16), .SAMPLE_DELAY(0), .LFSR_SEED(8'h01)) dut0 (
    .clock(clk), .reset(rst_n), .io_start(start), .io_abort(abort), .io_sum(sum[0]), .io_cout(cout[0]),
    .io_a(a[0]), .io_b(b[0]), .io_cin(ci[0]), .io_busy(busy[0]), .io_done(done[0]), .io_pass(pass[0]),
    .io_err_count(err[0]), .io_first_fail_idx(ffi[0]), .io_first_fail_vec(ffv[0]));
  full_adder_tester #(.NUM_VECTORS(16), .SAMPLE_DELAY(2), .LFSR_SEED(8'h00)) dut2 (
    .clock(clk), .reset(rst_n), .io_start(start), .io_abort(abort), .io_sum(sum[1]), .io_cout(cout[1]),
    .io_a(a[1]), .io_b(b[1]), .io_cin(ci[1]), .io_busy(busy[1]), .io_done(done[1]), .io_pass(pass[1]),
    .io_err_count(err[1]), .io_first_fail_idx(ffi[1]), .io_first_fail_vec(ffv[1]));
  // adder under test: mode 0 correct, 1 sum stuck at 0, 2 two-register output pipeline
  for (genvar i = 0; i < 2; i++) begin : g_adder
    logic s1 = 0, c1 = 0, s2 = 0, c2 = 0;
    always @(posedge clk) begin
      s1 <= a[i] ^ b[i] ^ ci[i];
      c1 <= (a[i] & b[i]) | (a[i] & ci[i]) | (b[i] & ci[i]);
      s2 <= s1;
      c2 <= c1;
    end
    assign sum[i] = (mode == 2) ? s2 : (mode == 1) ? 1'b0 : a[i] ^ b[i] ^ ci[i];
    assign cout[i] = (mode == 2) ? c2 : (a[i] & b[i]) | (a[i] & ci[i]) | (b[i] & ci[i]);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // vector k of a run: truth table first, then successive LFSR states (effective seed 8'h01)
  function automatic logic [2:0] vec_at(int k);
    logic [7:0] l;
    l = 8'h01;
    if (k < 8) return k[2:0];
    for (int j = 8; j <= k; j++) l = {l[6:0], ^(l & 8'hB8)};
    return l[2:0];
  endfunction
  // {cout,sum} is just the count of ones among a, b, cin
  function automatic logic [1:0] fa(logic [2:0] v);
    int s;
    s = v[0] + v[1] + v[2];
    return s[1:0];
  endfunction
  // what the faulty adder presents when vector k is sampled with delay d
  function automatic logic [1:0] resp(int d, int k);
    logic [1:0] r;
    int j;
    r = fa(vec_at(k));
    if (mode == 1) r[0] = 1'b0;
    if (mode == 2) begin
      j = (k + 1) * (d + 1) - 3;
      r = (j < 0) ? 2'b00 : fa(vec_at(j / (d + 1)));
    end
    return r;
  endfunction
  task automatic check_result(int i, int d, int ncmp, bit aborted, string tag);
    logic [15:0] e_err, e_ffi;
    logic [2:0] e_ffv;
    e_err = 0;
    e_ffi = 0;
    e_ffv = 0;
    for (int k = 0; k < ncmp; k++)
      if (resp(d, k) !== fa(vec_at(k))) begin
        if (e_err == 0) begin
          e_ffi = 16'(k);
          e_ffv = vec_at(k);
        end
        e_err++;
      end
    chk({tag, "_err"}, err[i], e_err);
    chk({tag, "_ffi"}, ffi[i], e_ffi);
    chk({tag, "_ffv"}, ffv[i], e_ffv);
    chk({tag, "_pass"}, pass[i], !aborted && e_err == 0);
    chk({tag, "_status"}, {busy[i], done[i], a[i], b[i], ci[i]}, 5'b01000);
  endtask
  task automatic check_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_out"}, {busy[i], done[i], pass[i], a[i], b[i], ci[i]}, 0);
      chk({tag, "_err"}, err[i], 0);
      chk({tag, "_ffi"}, ffi[i], 0);
      chk({tag, "_ffv"}, ffv[i], 0);
    end
  endtask
  task automatic run_full(string tag);
    start = 1;
    step();
    start = 0;
    for (int t = 0; t < 48; t++) begin
      chk({tag, "_vec0"}, {a[0], b[0], ci[0]}, (t < 16) ? vec_at(t) : 3'b000);
      chk({tag, "_vec2"}, {a[1], b[1], ci[1]}, vec_at(t / 3));
      chk({tag, "_done0"}, done[0], t >= 16);
      chk({tag, "_busy2"}, busy[1], 1);
      step();
    end
    check_result(0, 0, 16, 0, {tag, "0"});
    check_result(1, 2, 16, 0, {tag, "2"});
    repeat (3) step();
  endtask
  initial begin
    #2;
    check_zero("reset");
    #20 rst_n = 1;
    repeat (2) step();
    mode = 0;
    run_full("comb");
    mode = 1;
    run_full("stuck");
    chk("stuck_ffi_const", ffi[0], 1);
    chk("stuck_ffv_const", ffv[0], 3'b001);
    mode = 2;
    run_full("pipe");
    for (int r = 0; r < 4; r++) begin
      mode = int'($urandom_range(0, 2));
      c = int'($urandom_range(1, 40));
      start = 1;
      step();
      start = 0;
      if (c >= 2) begin
        start = 1;
        step();
        start = 0;
        repeat (c - 2) step();
      end
      abort = 1;
      step();
      abort = 0;
      check_result(0, 0, (c <= 16) ? c - 1 : 16, c <= 16, "abort0");
      check_result(1, 2, (c - 1) / 3, 1, "abort2");
      repeat (3) step();
    end
    mode = 1;
    start = 1;
    step();
    start = 0;
    repeat (4) step();
    chk("pre_rst_err", err[0], 2);
    #2 rst_n = 0;
    #1 check_zero("async_rst");
    repeat (2) step();
    rst_n = 1;
    repeat (3) step();
    check_zero("idle_after_rst");
    mode = 0;
    run_full("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/full_adder_tester.md
# full_adder_tester

- Self-checking hardware stimulus/response engine for the `FullAdder` block.
- It drives `a`/`b`/`cin` vectors into the adder, samples `sum`/`cout` after a programmable delay, compares them against a golden model, and reports the pass/fail result.
- It sits beside the adder on-chip and replaces the simulation-only test harness for silicon bring-up and FPGA self-test.

## Interface
Parameters:
- NUM_VECTORS, 64: vectors per run; legal range 1..65535.
- SAMPLE_DELAY, 0: extra cycles between driving a vector and sampling the DUT; legal range 0..15.
- LFSR_SEED, 8'h01: LFSR seed for vectors 8 and up; a value of 0 is replaced by 8'h01.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_start  in  1  level-sampled run request.
- io_abort  in  1  ends the current run early.
- io_sum  in  1  DUT sum output.
- io_cout  in  1  DUT carry-out.
- io_a  out  1  DUT operand a.
- io_b  out  1  DUT operand b.
- io_cin  out  1  DUT carry-in.
- io_busy  out  1  run in progress.
- io_done  out  1  run finished; held until the next start.
- io_pass  out  1  valid while io_done=1: no mismatches and not aborted.
- io_err_count  out  16  mismatch count; saturates at 16'hFFFF.
- io_first_fail_idx  out  16  index of the first mismatching vector.
- io_first_fail_vec  out  3  {a,b,cin} of the first mismatching vector.

## Operation
- While reset=0, every output and register is 0 and the FSM is in IDLE. The LFSR loads the effective seed.
- States and transitions:
  - IDLE: io_start=1 goes to RUN. On entry to RUN, clear io_err_count, io_first_fail_*, the vector index k and the sample timer. Reload the LFSR.
  - RUN: drive vector k and count SAMPLE_DELAY+1 cycles. At the end of the count, compare, advance k, and drive vector k+1. After the compare of vector NUM_VECTORS-1, go to DONE.
  - DONE: io_done=1. io_start=1 restarts the run; the clear happens exactly as from IDLE.
- Vector generation:
  - For k<8, {a,b,cin}=k[2:0].
  - For k>=8, {a,b,cin}=lfsr[2:0]. The LFSR is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift-left with feedback into bit 0. It advances once per vector for k>=8, with the first advance occurring before vector 8 is driven.
- Golden model:
  - sum = a^b^cin.
  - cout = (a&b)|(a&cin)|(b&cin).
  - A mismatch on sum, cout or both counts as one error.
- Error recording:
  - On the first error of a run, latch k into io_first_fail_idx and the vector into io_first_fail_vec. Later errors do not update them.
  - The error counter saturates at 16'hFFFF and never wraps.
- Outputs outside RUN: io_a/io_b/io_cin are 0 whenever io_busy=0.
- io_pass = io_done & (io_err_count==0) & ~aborted.
- Abort: io_abort=1 in RUN moves the FSM to DONE on that edge. No compare happens on that edge. The aborted flag is set and forces io_pass=0. The flag is cleared on the next start.
- io_start in RUN is ignored.
- If io_start and io_abort are both high in IDLE or DONE, io_start wins.

## Timing
- Let E0 be the edge that samples io_start=1.
  - From E0: io_busy=1, io_done=0, and vector 0 is on io_a/b/cin.
- With D=SAMPLE_DELAY:
  - Vector k is driven from edge E0+k(D+1).
  - Vector k is sampled at edge E0+(k+1)(D+1), the same edge that drives vector k+1.
  - The DUT must settle within D+1 cycles, so a combinational DUT works with D=0.
- Run completion:
  - At edge E0+N(D+1): io_busy=0, io_done=1, and io_a/b/cin=0.
  - Total run length is N(D+1) cycles.
- io_err_count and io_first_fail_* update on the same edge as the compare.
- A reset assertion mid-run clears all state immediately (asynchronous). After deassertion the block waits in IDLE.

## Test plan
- Correct combinational DUT, N=8, D=0, start pulse → io_a/b/cin step 0..7 one per cycle; io_done rises 8 cycles after E0; pass=1, err=0.
- DUT with sum stuck at 0, N=8 → err=4, first_fail_idx=1, first_fail_vec=3'b001, pass=0.
- DUT with a 2-register output pipeline, N=16, D=2 → pass=1, done at E0+48. Same DUT with D=0 → pass=0, err>0.
- N=16, seed 8'h01 → vectors 8..15 equal bits [2:0] of successive LFSR states 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C. Check each against an independent model.
- Abort at cycle 3 of an N=64 run → done=1 and pass=0 on the next cycle; err counts only compares before the abort. io_start while busy has no effect.
- reset=0 at cycle 5 of a run → all outputs 0 asynchronously. After release, a new start runs a clean full pass from vector 0.
